// File: rtl/systolic_drain.sv
// systolic_drain: captures psum beats from the systolic array into a beat FIFO,
// serves them to the result writer over valid/ready, counts beats against a
// programmed total and reports done once everything has been drained.
// Optional build macro: DRAIN_WORD_REVERSE_EN reverses word order inside each
// stored beat (word v of the stored beat = input word WORDS_PER_BEAT-1-v).
module systolic_drain #(
  parameter int C_WIDTH        = 32,
  parameter int WORDS_PER_BEAT = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              expected_count,
  input  logic [C_WIDTH*WORDS_PER_BEAT-1:0] in_data,
  input  logic                              in_valid,
  output logic [C_WIDTH*WORDS_PER_BEAT-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CNT_WIDTH-1:0]              beat_count,
  output logic                              overflow,
  output logic                              done,
  output logic                              busy
);

  localparam int BW = C_WIDTH * WORDS_PER_BEAT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Word ordering applied to a beat before it is stored.
  function automatic logic [BW-1:0] order_words(input logic [BW-1:0] beat);
    logic [BW-1:0] res;
`ifdef DRAIN_WORD_REVERSE_EN
    res = '0;
    for (int v = 0; v < WORDS_PER_BEAT; v++) begin
      res[v*C_WIDTH +: C_WIDTH] = beat[(WORDS_PER_BEAT-1-v)*C_WIDTH +: C_WIDTH];
    end
`else
    res = beat;
`endif
    return res;
  endfunction

  state_t               state_r;
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [BW-1:0]        mem_r [FIFO_DEPTH];
  logic [BW-1:0]        out_data_r;
  logic                 out_valid_r;
  logic [CNT_WIDTH-1:0] beat_count_r;
  logic [CNT_WIDTH-1:0] target_r;
  logic                 overflow_r;
  logic                 done_r;
  logic                 busy_r;

  logic                 pop_s;
  logic                 full_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 drop_s;
  logic [PW-1:0]        wr_ptr_nxt_s;
  logic [PW-1:0]        rd_ptr_nxt_s;
  logic                 empty_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic [BW-1:0]        wdata_s;
  logic [BW-1:0]        head_nxt_s;

  // Handshake decode, next pointers, saturating count and next head entry.
  always_comb begin
    pop_s    = out_valid_r && out_ready;
    full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
               (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    accept_s = (state_r == ST_RUN) && in_valid;
    // A full FIFO still has room when its head leaves in the same cycle.
    push_s   = accept_s && (!full_s || pop_s);
    drop_s   = accept_s && !push_s;
    wdata_s  = order_words(in_data);

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);

    if (beat_count_r == {CNT_WIDTH{1'b1}}) begin
      cnt_inc_s = beat_count_r;
    end else begin
      cnt_inc_s = beat_count_r + CNT_WIDTH'(1);
    end

    // The slot that becomes head may be the one written this very cycle.
    if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      head_nxt_s = wdata_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Beat storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
    end
  end

  // FIFO pointers and the registered head beat presented to the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      out_valid_r <= !empty_nxt_s;
      if (!empty_nxt_s) begin
        out_data_r <= head_nxt_s;
      end
    end
  end

  // Drain control FSM with beat counting, overflow flag and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      beat_count_r <= '0;
      target_r     <= '0;
      overflow_r   <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            beat_count_r <= '0;
            overflow_r   <= 1'b0;
            target_r     <= expected_count;
            if (expected_count == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RUN;
              done_r  <= 1'b0;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            beat_count_r <= cnt_inc_s;
            if (drop_s) begin
              overflow_r <= 1'b1;
            end
            if (cnt_inc_s == target_r) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (empty_nxt_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign beat_count = beat_count_r;
  assign overflow   = overflow_r;
  assign done       = done_r;
  assign busy       = busy_r;

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Parametrised output drain for the systolic array: captures `psum` beats whenever the array raises `valid_out`, optionally reverses word order within each beat, and buffers them in a FIFO. Downstream logic reads the FIFO through a valid/ready handshake. The block counts beats against a programmed total and asserts `done` once every expected beat has been accepted and drained. It replaces bench-side output counting and termination with synthesizable logic that sits between `systolic` and the result writer.

## Interface
- `C_WIDTH`, 32, bits per output word.
- `WORDS_PER_BEAT`, 4, words per psum beat; beat width `BW = C_WIDTH*WORDS_PER_BEAT`.
- `FIFO_DEPTH`, 16, beat entries; must be a power of two and at least 2.
- `CNT_WIDTH`, 32, width of the beat counters.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that arms a new drain.
- `expected_count` in `CNT_WIDTH`: number of beats to collect; sampled on `start`.
- `in_data` in `BW`: psum beat from the array.
- `in_valid` in 1: beat qualifier; the array's `valid_out`. There is no backpressure toward the array.
- `out_data` out `BW`: head-of-FIFO beat.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head beat.
- `beat_count` out `CNT_WIDTH`: beats accepted since the last `start`, dropped beats included.
- `overflow` out 1: sticky flag; set when a beat was dropped because the FIFO was full.
- `done` out 1: high in state DONE.
- `busy` out 1: high in state RUN or FLUSH.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE. Encoding is free.
- IDLE:
  - `in_valid` is ignored.
  - `start` with `expected_count`≠0 → RUN.
  - `start` with `expected_count`=0 → DONE.
- RUN:
  - Each cycle with `in_valid`=1 increments `beat_count`.
  - That beat is pushed if there is space, which means the FIFO is not full, or a pop happens in the same cycle.
  - If there is no space, the beat is dropped and `overflow` is set. The beat still counts.
  - When the increment makes `beat_count` equal to `expected_count` → FLUSH.
- FLUSH:
  - `in_valid` is ignored; extra beats are neither stored nor counted.
  - When the FIFO becomes empty (including the cycle of its last pop) → DONE.
- DONE:
  - `done`=1 and `in_valid` is ignored.
  - `start` re-arms the block exactly as it does from IDLE.
- `start` in RUN or FLUSH is ignored.
- `start` clears `beat_count` and `overflow` and loads the internal target. FIFO contents are not flushed. In practice the FIFO is already empty in IDLE and DONE.
- Pop occurs when `out_valid && out_ready`.
- Push and pop in the same cycle are both performed, including when the FIFO is full, and occupancy is unchanged.
- Read and write pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally.
  - Full: the MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.
- `beat_count` saturates at all-ones and does not wrap.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `beat_count`=0, `overflow`=0, `done`=0, `busy`=0. The FSM returns to IDLE and both pointers to 0.
- Reset asserted mid-operation aborts immediately. The FIFO contents are discarded because both pointers are cleared.
- Latency: a beat sampled at edge N is visible on `out_data` with `out_valid`=1 after edge N, i.e. in the next cycle.
- `out_data` is the registered head entry, driven from storage with no combinational path from `in_data`.
- `out_data` and `out_valid` hold stable while `out_valid && !out_ready`.
- `busy` rises the cycle after `start`.
- `done` rises one cycle after the last pop, or one cycle after `start` when `expected_count`=0.
- Throughput: one beat in and one beat out per cycle.

## Configuration
- `DRAIN_WORD_REVERSE_EN` defined: the stored beat reverses word order. For v in 0..WORDS_PER_BEAT-1, stored word v = `in_data` word (WORDS_PER_BEAT-1-v); word v occupies bits [(v+1)*C_WIDTH-1 : v*C_WIDTH].
- Undefined: beats are stored unmodified.
- Latency, counting and the handshake are identical in both builds.

## Test plan
- Reset, then `start` with `expected_count`=3; drive 3 consecutive beats with `out_ready`=1 → beats appear in order one cycle after each is sampled, `beat_count`=3, and `done`=1 one cycle after the third pop.
- `DRAIN_WORD_REVERSE_EN` with C_WIDTH=32, WPB=4 and `in_data`=0x00000004_00000003_00000002_00000001 → `out_data`=0x00000001_00000002_00000003_00000004. Without the macro, `out_data` equals `in_data`.
- `out_ready`=0, `expected_count`=20, 17 beats of DEPTH=16 → `out_valid` stays high, the 17th beat is dropped, `overflow`=1 and `beat_count`=17. Then raise `out_ready` → exactly 16 beats drain.
- FIFO full with a simultaneous push and pop → occupancy stays 16, `overflow` stays 0 and order is preserved across pointer wrap.
- `start` with `expected_count`=0 → `done`=1 on the next cycle and no beat is accepted. Extra `in_valid` beats in FLUSH or DONE leave `beat_count` unchanged.
- Assert `rst` low during RUN with 5 beats buffered → all outputs are at reset values immediately. After `rst` is released, `out_valid`=0 until a new `start`.
